// File: rtl/stream_pack_if.sv
// AXI4-Stream master-side bundle for stream_pack: valid/data/last forward,
// ready backward. The packer drives through the master modport.
interface stream_pack_if #(
  parameter int DW = 32
);
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;

  modport master (output m_tvalid, output m_tdata, output m_tlast, input m_tready);
  modport slave  (input  m_tvalid, input  m_tdata, input  m_tlast, output m_tready);
endinterface

// File: rtl/stream_pack.sv
// stream_pack: snapshots CORENUM core results on a load pulse and emits them
// one core per beat on an AXI4-Stream master, honouring backpressure.
// Optional header beat (16-bit frame sequence number) when the macro
// STREAM_PACK_HDR_EN is defined; default build has no header.
module stream_pack #(
  parameter int CORENUM = 16,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CORENUM*DW-1:0] core_data,
  stream_pack_if.master         m_axis,
  output logic                  busy,
  output logic                  drop_err
);

`ifdef STREAM_PACK_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FLEN = CORENUM + HDR;
  localparam int IW   = $clog2(CORENUM + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state, state_n;
  logic [IW-1:0]               idx, idx_n;
  logic [CORENUM-1:0][DW-1:0]  snap, snap_n;
  logic                        hs, last, capture, drop;
  logic                        tvalid_n, tlast_n;
  logic [DW-1:0]               tdata_n;
`ifdef STREAM_PACK_HDR_EN
  logic [15:0]                 seq, seq_n;
`endif

  assign hs   = m_axis.m_tvalid & m_axis.m_tready;
  assign last = (idx == LAST_IDX);

  // Registers: state, beat index, snapshot and all (registered) outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      snap            <= '0;
      m_axis.m_tvalid <= 1'b0;
      m_axis.m_tdata  <= '0;
      m_axis.m_tlast  <= 1'b0;
      busy            <= 1'b0;
      drop_err        <= 1'b0;
`ifdef STREAM_PACK_HDR_EN
      seq             <= '0;
`endif
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      snap            <= snap_n;
      m_axis.m_tvalid <= tvalid_n;
      m_axis.m_tdata  <= tdata_n;
      m_axis.m_tlast  <= tlast_n;
      busy            <= (state_n == SEND);
      drop_err        <= drop_err | drop;
`ifdef STREAM_PACK_HDR_EN
      seq             <= seq_n;
`endif
    end
  end

  // Next state / index: load is only taken in IDLE or on the final handshake;
  // anywhere else in SEND it is dropped and flagged.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    capture = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (hs && last) begin
          idx_n = '0;
          if (load) capture = 1'b1;
          else      state_n = IDLE;
        end else begin
          if (hs)   idx_n = idx + 1'b1;
          if (load) drop  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    snap_n = capture ? core_data : snap;
`ifdef STREAM_PACK_HDR_EN
    seq_n = (hs && last) ? seq + 16'd1 : seq;
`endif
  end

  // Next output values, computed from next state so outputs can be registered
  // without a cycle of lag (beat 0 is visible the cycle after load).
  always_comb begin
    tvalid_n = (state_n == SEND);
    tlast_n  = tvalid_n && (idx_n == LAST_IDX);
    tdata_n  = '0;
    if (tvalid_n) begin
      for (int k = 0; k < CORENUM; k++)
        if (idx_n == IW'(k + HDR)) tdata_n = snap_n[k];
`ifdef STREAM_PACK_HDR_EN
      if (idx_n == '0) tdata_n = DW'(seq_n);
`endif
    end
  end

endmodule

// File: tb/tb_stream_pack.sv
// Directed bench for stream_pack with CORENUM=4, DW=32. Follows the header
// build automatically when STREAM_PACK_HDR_EN is defined.
module tb_stream_pack;
  localparam int CORENUM = 4;
  localparam int DW      = 32;
`ifdef STREAM_PACK_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FL = CORENUM + HDR;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  load;
  logic [CORENUM*DW-1:0] core_data;
  logic                  busy, drop_err;
  int                    n_checks = 0;
  int                    n_fail   = 0;
  int                    exp_seq  = 0;

  stream_pack_if #(.DW(DW)) axis ();

  stream_pack #(.CORENUM(CORENUM), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .core_data (core_data),
    .m_axis    (axis),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int base);
    for (int k = 0; k < CORENUM; k++) core_data[k*DW +: DW] = DW'(base + k);
  endtask

  function automatic logic [DW-1:0] exp_beat(input int b, input int base, input int seq);
    if (HDR != 0 && b == 0) return DW'(seq & 16'hffff);
    return DW'(base + b - HDR);
  endfunction

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; axis.m_tready = 1'b1; set_core(0);
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (axis.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", axis.m_tvalid); end
    n_checks++; if (axis.m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", axis.m_tdata); end
    n_checks++; if (axis.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", axis.m_tlast); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b exp 0", drop_err); end
    exp_seq = 0;
  endtask

  task automatic test_basic;
    axis.m_tready = 1'b1; set_core(32'hA0);
    load = 1'b1; tick(); load = 1'b0;
    for (int b = 0; b < FL; b++) begin
      n_checks++; if (axis.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_tvalid beat %0d got %b exp 1", b, axis.m_tvalid); end
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hA0, exp_seq)) begin n_fail++; $display("FAIL basic_tdata beat %0d got %h exp %h", b, axis.m_tdata, exp_beat(b, 32'hA0, exp_seq)); end
      n_checks++; if (axis.m_tlast !== (b == FL-1)) begin n_fail++; $display("FAIL basic_tlast beat %0d got %b exp %b", b, axis.m_tlast, b == FL-1); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy beat %0d got %b exp 1", b, busy); end
      tick();
    end
    exp_seq++;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    n_checks++; if (axis.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_tvalid_end got %b exp 0", axis.m_tvalid); end
    n_checks++; if (axis.m_tlast !== 1'b0) begin n_fail++; $display("FAIL basic_tlast_end got %b exp 0", axis.m_tlast); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %b exp 0", drop_err); end
  endtask

  task automatic test_backpressure;
    axis.m_tready = 1'b1; set_core(32'hA0);
    load = 1'b1; tick(); load = 1'b0;
    for (int b = 0; b < FL; b++) begin
      if (b == 1 || b == 2) begin
        axis.m_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hA0, exp_seq)) begin n_fail++; $display("FAIL bp_stall_tdata beat %0d cyc %0d got %h exp %h", b, s, axis.m_tdata, exp_beat(b, 32'hA0, exp_seq)); end
          n_checks++; if (axis.m_tlast !== (b == FL-1) || axis.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_ctl beat %0d cyc %0d got v%b l%b exp v1 l%b", b, s, axis.m_tvalid, axis.m_tlast, b == FL-1); end
          tick();
        end
        axis.m_tready = 1'b1;
      end
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hA0, exp_seq)) begin n_fail++; $display("FAIL bp_tdata beat %0d got %h exp %h", b, axis.m_tdata, exp_beat(b, 32'hA0, exp_seq)); end
      n_checks++; if (axis.m_tlast !== (b == FL-1)) begin n_fail++; $display("FAIL bp_tlast beat %0d got %b exp %b", b, axis.m_tlast, b == FL-1); end
      tick();
    end
    exp_seq++;
    n_checks++; if (axis.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_end_tvalid got %b exp 0", axis.m_tvalid); end
  endtask

  task automatic test_snapshot;
    axis.m_tready = 1'b1; set_core(32'hA0);
    load = 1'b1; tick(); load = 1'b0;
    core_data = '1;
    for (int b = 0; b < FL; b++) begin
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hA0, exp_seq)) begin n_fail++; $display("FAIL snap_tdata beat %0d got %h exp %h", b, axis.m_tdata, exp_beat(b, 32'hA0, exp_seq)); end
      tick();
    end
    exp_seq++;
  endtask

  task automatic test_drop_chain;
    axis.m_tready = 1'b1; set_core(32'hA0);
    load = 1'b1; tick(); load = 1'b0;
    for (int b = 0; b < FL; b++) begin
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hA0, exp_seq) || axis.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL chain_f1 beat %0d got %h v%b exp %h v1", b, axis.m_tdata, axis.m_tvalid, exp_beat(b, 32'hA0, exp_seq)); end
      if (b == 1) begin set_core(32'hB0); load = 1'b1; end
      if (b == FL-1) begin set_core(32'hC0); load = 1'b1; end
      tick();
      load = 1'b0;
      if (b == 1) begin
        n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b exp 1", drop_err); end
      end
    end
    exp_seq++;
    for (int b = 0; b < FL; b++) begin
      n_checks++; if (axis.m_tvalid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL chain_f2_valid beat %0d got v%b busy%b exp 1 1", b, axis.m_tvalid, busy); end
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hC0, exp_seq)) begin n_fail++; $display("FAIL chain_f2_tdata beat %0d got %h exp %h", b, axis.m_tdata, exp_beat(b, 32'hC0, exp_seq)); end
      n_checks++; if (axis.m_tlast !== (b == FL-1)) begin n_fail++; $display("FAIL chain_f2_tlast beat %0d got %b exp %b", b, axis.m_tlast, b == FL-1); end
      tick();
    end
    exp_seq++;
    n_checks++; if (busy !== 1'b0 || drop_err !== 1'b1) begin n_fail++; $display("FAIL chain_end got busy%b drop%b exp busy0 drop1", busy, drop_err); end
  endtask

  task automatic test_midreset;
    axis.m_tready = 1'b1; set_core(32'hA0);
    load = 1'b1; tick(); load = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_seq = 0;
    n_checks++; if (axis.m_tvalid !== 1'b0 || axis.m_tlast !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got v%b l%b exp v0 l0", axis.m_tvalid, axis.m_tlast); end
    n_checks++; if (busy !== 1'b0 || drop_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags got busy%b drop%b exp 0 0", busy, drop_err); end
    n_checks++; if (axis.m_tdata !== '0) begin n_fail++; $display("FAIL mid_rst_tdata got %h exp 0", axis.m_tdata); end
    // rst and load together: rst wins
    rst = 1'b1; load = 1'b1; tick(); rst = 1'b0; load = 1'b0;
    n_checks++; if (axis.m_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_load got v%b busy%b exp 0 0", axis.m_tvalid, busy); end
    set_core(32'hD0);
    load = 1'b1; tick(); load = 1'b0;
    for (int b = 0; b < FL; b++) begin
      n_checks++; if (axis.m_tdata !== exp_beat(b, 32'hD0, exp_seq) || axis.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL restart beat %0d got %h v%b exp %h v1", b, axis.m_tdata, axis.m_tvalid, exp_beat(b, 32'hD0, exp_seq)); end
      tick();
    end
    exp_seq++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_drop_chain();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_pack.md
# stream_pack

Output packer directly downstream of the stream controller. It snapshots the per-core result registers on a single load pulse and serializes them one core per beat onto the AXI4-Stream master port (M_AXIS). It owns TDATA, TVALID and TLAST ordering and enforces AXI backpressure, so core results may change as soon as the snapshot is taken.

## Interface
- CORENUM, 16, number of cores; one beat per core per frame
- DW, 32, result width per core and TDATA width
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- load  in  1  single-cycle pulse: capture core_data and start a frame
- core_data  in  CORENUM*DW  concatenated core results; core k at bits [k*DW +: DW]
- m_tready  in  1  downstream ready
- m_tvalid  out  1  beat valid
- m_tdata  out  DW  beat data
- m_tlast  out  1  final beat of frame
- busy  out  1  frame in progress (state SEND)
- drop_err  out  1  sticky: a load arrived while the block could not accept it; cleared only by rst

## Operation
- States: IDLE, SEND.
- IDLE: m_tvalid=0. When load=1, copy core_data into the snapshot register, set idx=0 and enter SEND.
- SEND: m_tvalid=1 and m_tdata=snapshot[idx]. m_tlast=1 when idx==CORENUM-1.
- Handshake is m_tvalid & m_tready.
  - Handshake with idx<CORENUM-1: idx+1.
  - Handshake with idx==CORENUM-1: frame done. Return to IDLE, unless load=1 in the same cycle; then capture the new snapshot, set idx=0 and stay in SEND.
- While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and idx hold.
- m_tvalid never depends combinationally on m_tready. All outputs are registered.
- load in SEND is accepted only in the cycle of the final handshake. Otherwise it is ignored, drop_err is set to 1 and the frame in flight is unaffected.
- idx width is $clog2(CORENUM+1). It never exceeds the frame length minus 1 and does not wrap.
- CORENUM=1: every beat has m_tlast=1.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, drop_err=0, idx=0, state=IDLE.
- Latency: load at cycle t gives the first beat valid at t+1. Snapshot is core_data sampled at edge t.
- Throughput: 1 beat/cycle while m_tready=1. A frame takes CORENUM cycles (plus header, see Configuration).
- Back-to-back frames: load coincident with the final handshake gives no bubble. The next frame's beat 0 is valid the following cycle.
- rst mid-frame: at the next edge all outputs return to reset values. The frame is abandoned with no m_tlast.
- rst and load in the same cycle: rst wins and load is ignored.
- busy rises at t+1 after load and falls the cycle after the final handshake (unless chained).

## Configuration
- STREAM_PACK_HDR_EN defined:
  - Each frame starts with one header beat: m_tdata = {zero pad, 16-bit frame sequence number}.
  - The sequence number resets to 0 and increments by 1 per completed frame, wrapping at 16 bits.
  - Frame length is CORENUM+1 beats. m_tlast is on the last core beat. idx range is 0..CORENUM.
- Macro undefined: no header, no sequence counter; the frame is exactly CORENUM core beats.

## Test plan
- Basic frame: CORENUM=4, DW=32, core k = 0xA0+k, load at t, m_tready=1 → beats 0xA0, 0xA1, 0xA2, 0xA3 at t+1..t+4; m_tlast only at t+4; busy low at t+5.
- Backpressure: as above with m_tready=0 on beats 1 and 2 for 3 cycles each → m_tdata/m_tlast stable while stalled; the same 4 values in order with no duplicates.
- Snapshot isolation: change core_data to all 0xFF at t+1 → output still 0xA0..0xA3.
- Chaining and drop: load during beat 1 → drop_err=1, frame unchanged. Load coincident with the beat-3 handshake → second frame beat 0 valid next cycle, no gap.
- Reset mid-frame: rst during beat 2 → next cycle m_tvalid=0, m_tlast=0, busy=0, drop_err=0. A new load then restarts from core 0.
- HDR_EN: two frames → header data 0x0000 then 0x0001; 5 beats per frame; m_tlast on the 5th beat.
